// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states, access owner
// and the default data-grant streak limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int unsigned MAX_D_STREAK_DEF = 4;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side command/response bus. The arbiter is the master, the memory
// is the slave.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requesters. Data wins unless it has
// already taken MAX_D_STREAK grants in a row while a fetch was waiting.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    input  logic if_kill,
    input  logic grant_evt,
    output logic grant_i,
    output logic grant_d
);
    localparam int unsigned CNT_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    logic [CNT_W-1:0] streak;

    always_comb begin
        grant_d = grant_evt & d_req & (~if_req | (streak < STREAK_MAX));
        grant_i = grant_evt & ~grant_d & if_req & ~if_kill;
    end

    // Saturating; only data grants taken while a fetch waits count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant_i) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!if_req)
                streak <= '0;
            else if (streak != STREAK_MAX)
                streak <= streak + 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported variable-latency memory between fetch and data.
// state | meaning
// IDLE  | no access in flight, grant decision made here
// ISSUE | mem_req held with command until mem_gnt
// WAIT  | command accepted, waiting for mem_rvalid
// RESP  | owner's ack pulse visible (unless fetch was killed)
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_kill,
    output logic                  if_ack,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  stall_F,
    output logic                  stall_M,
    unified_mem_arbiter_if.master mem
);
    arb_state_t state;
    owner_t     owner;
    logic       kill_flag;
    logic       idle;
    logic       grant_i;
    logic       grant_d;

    assign idle    = (state == ST_IDLE);
    assign stall_F = if_req & ~if_ack;
    assign stall_M = d_req & ~d_ack;

    mem_arb_prio #(.MAX_D_STREAK(MAX_D_STREAK)) u_prio (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .d_req     (d_req),
        .if_kill   (if_kill),
        .grant_evt (idle),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            owner         <= OWN_I;
            kill_flag     <= 1'b0;
            if_ack        <= 1'b0;
            d_ack         <= 1'b0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    kill_flag <= 1'b0;
                    if (grant_d) begin
                        owner         <= OWN_D;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= d_we;
                        mem.mem_addr  <= d_addr;
                        mem.mem_wdata <= d_wdata;
                        state         <= ST_ISSUE;
                    end else if (grant_i) begin
                        owner         <= OWN_I;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= if_addr;
                        mem.mem_wdata <= '0;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (owner == OWN_I && if_kill)
                        kill_flag <= 1'b1;
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (owner == OWN_I && if_kill)
                        kill_flag <= 1'b1;
                    // Ack is registered here so it is visible during RESP;
                    // a kill arriving alongside rvalid must still suppress it.
                    if (mem.mem_rvalid) begin
                        state <= ST_RESP;
                        if (owner == OWN_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem.mem_we ? '0 : mem.mem_rdata;
                        end else if (!(kill_flag | if_kill)) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem.mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    kill_flag <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between two requesters of the 5-stage pipeline: instruction fetch (F stage) and the data load/store port (M stage).
- Sequences each access through a request/grant/response handshake on the memory side.
- Drives per-stage stall signals so the pipeline freezes while its access is outstanding.
- Data accesses have priority; a streak limit guarantees fetch forward progress.

Parameters:
ADDR_W, 32, address width for both requesters and memory
DATA_W, 32, data width
MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_ack or if_kill
if_addr  in  ADDR_W  fetch address (PC)
if_kill  in  1  branch flush; discard the outstanding/pending fetch
if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held stable with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address (ALU result)
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse; d_rdata valid on loads
d_rdata  out  DATA_W  load data; 0 on store ack
stall_F  out  1  if_req & ~if_ack (combinational)
stall_M  out  1  d_req & ~d_ack (combinational)
mem_req  out  1  memory command valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_gnt  in  1  memory accepts the command this cycle (mem_req & mem_gnt)
mem_rvalid  in  1  response/completion; one pulse per accepted command, for loads and stores
mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid

Behaviour:
- Reset is asynchronous: all state goes to IDLE.
  - if_ack, d_ack, mem_req, mem_we = 0.
  - if_rdata, d_rdata, mem_addr, mem_wdata = 0.
  - Streak counter = 0; kill flag = 0.
- Reset mid-transaction abandons the transaction. The memory shares rst_n.
- FSM states are IDLE, ISSUE, WAIT, RESP. A 1-bit owner register records I or D.
- IDLE:
  - If d_req and (~if_req or streak < MAX_D_STREAK), grant D.
  - Otherwise, if if_req & ~if_kill, grant I.
  - On a grant: latch the command into the mem_* registers and go to ISSUE.
- ISSUE:
  - mem_req = 1 with the command held constant.
  - On mem_gnt, drop mem_req and go to WAIT.
  - A command, once issued, is never retracted.
- WAIT:
  - On mem_rvalid, capture mem_rdata and go to RESP.
  - mem_rvalid in any other state is ignored.
- RESP, one cycle:
  - Pulse the owner's ack with the registered rdata, then go to IDLE.
  - On a store, d_rdata = 0.
  - Fetch kill: if the kill flag is set and owner = I, suppress if_ack and leave if_rdata unchanged.
- Minimum latency:
  - Request visible in IDLE at cycle 0, mem_req at cycle 1 (gnt same cycle), mem_rvalid at cycle 2, ack at cycle 3.
  - Each extra gnt or rvalid wait cycle adds one cycle.
- Back-to-back requests:
  - In the cycle after an ack, the FSM is in IDLE.
  - Requesters update req/addr on the ack edge, so the same request is never serviced twice.
- Streak counter (saturating):
  - Increments on each D grant made while if_req is high.
  - Clears on any I grant, or when if_req is low at a D grant.
- Kill flag:
  - Set when if_kill = 1 while owner = I in ISSUE or WAIT.
  - Cleared on entry to IDLE.
  - if_kill in IDLE blocks an I grant that cycle.
- Simultaneous if_req and d_req in IDLE with streak < MAX: D wins.
- d_req is never killed.
- stall_F and stall_M are purely combinational from req/ack. No registered path creates a stall bubble.

Decomposition:
- Shared package (mem_arb_pkg) holds:
  - the FSM state encoding,
  - the owner encoding (OWN_I = 0, OWN_D = 1),
  - the default MAX_D_STREAK.
- One natural sub-module: mem_arb_prio, combinational grant selection plus the streak counter register, with inputs if_req, d_req, if_kill, grant_evt and outputs grant_i, grant_d.
- The top level holds the FSM, command and response registers.

Test Plan:
1. Single load with d_addr=0x40, mem_gnt tied 1, mem_rvalid 1 cycle after gnt, mem_rdata=0xDEADBEEF -> mem_req at cycle 1, d_ack at cycle 3 with d_rdata=0xDEADBEEF, stall_M=1 for cycles 0-2.
2. Store with d_addr=0x80, d_wdata=0x1234, mem_gnt delayed 3 cycles -> mem_req held 4 cycles with constant addr/data, mem_we=1; d_ack with d_rdata=0 at cycle 6.
3. Simultaneous if_req (addr 0x100) and d_req (addr 0x200) -> D issued first; I issued in the cycle after d_ack; if_ack is delivered second.
4. if_req held, d_req continuously reasserted, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D...; fetch completes after the 4th data ack.
5. Fetch at 0x10; if_kill pulsed during WAIT; mem_rvalid returns 0xAAAA -> no if_ack; if_rdata unchanged; FSM returns to IDLE; next fetch at 0x20 acks normally.
6. rst_n low during WAIT of a load -> all outputs 0 asynchronously; after release, a new load at 0x44 completes with minimum latency; a stray mem_rvalid in IDLE is ignored.
